// File: rtl/seqpu_serial_core.sv
// Accumulator CPU with digit-serial ALU: load/store take 3 cycles and ALU ops take 2+WIDTH/DIGIT cycles.
// FETCH/LOAD/STORE stall until mem_ready is high at an edge; the ALU ignores mem_ready.
module seqpu_serial_core #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             wren_n,
  input  logic             mem_ready,
  output logic             flag_c
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [2:0] {FETCH, DECODE, LOAD, STORE, ALU} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc, a, b, op, res;
  logic             c, cy;
  logic [CW-1:0]    counter;

  logic [1:0]       cls, dest;
  logic [2:0]       aluop;
  logic [WIDTH-1:0] addr_f, lit_f;

  assign cls    = op[WIDTH-1 -: 2];
  assign aluop  = op[WIDTH-3 -: 3];
  assign dest   = op[WIDTH-6 -: 2];
  assign addr_f = {2'b00, op[WIDTH-3:0]};
  assign lit_f  = {5'b00000, op[WIDTH-6:0]};

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   sum;
  logic             cy_in, cy_out, c_new;
  logic [WIDTH-1:0] r_full;

  // One digit per cycle; cy carries the add/sub carry or the shifted-out bit between digits.
  always_comb begin
    a_dig  = a[int'(counter)*DIGIT +: DIGIT];
    b_dig  = b[int'(counter)*DIGIT +: DIGIT];
    cy_in  = (counter == '0) ? (aluop == 3'b001) : cy;
    sum    = '0;
    case (aluop)
      3'b000:  sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, cy_in};
      3'b001:  sum = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT{1'b0}}, cy_in};
      3'b010:  sum = {1'b0, a_dig | b_dig};
      3'b011:  sum = {1'b0, a_dig & b_dig};
      3'b100:  sum = {1'b0, a_dig ^ b_dig};
      3'b101:  sum = {1'b0, ~(a_dig ^ b_dig)};
      3'b110:  sum = {1'b0, a_dig};
      default: sum = {a_dig, cy_in};
    endcase
    cy_out = sum[DIGIT];
    r_full = res;
    r_full[int'(counter)*DIGIT +: DIGIT] = sum[DIGIT-1:0];
  end

  always_comb begin
    case (aluop)
      3'b000:  c_new = cy_out;
      3'b001:  c_new = ~cy_out;
      3'b111:  c_new = cy_out;
      default: c_new = (r_full == '0);
    endcase
  end

  always_comb begin
    address = pc;
    if (state == LOAD || state == STORE) address = addr_f;
  end

  assign data_out = a;
  assign wren_n   = (state != STORE);
  assign flag_c   = c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      a       <= '0;
      b       <= '0;
      op      <= '0;
      c       <= 1'b0;
      counter <= '0;
      res     <= '0;
      cy      <= 1'b0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          op    <= data_in;
          pc    <= pc + 1'b1;
          state <= DECODE;
        end
        DECODE: begin
          counter <= '0;
          case (cls)
            2'b00: state <= LOAD;
            2'b01: state <= STORE;
            2'b10: begin
              a     <= lit_f;
              state <= ALU;
            end
            default: state <= ALU;
          endcase
        end
        LOAD: if (mem_ready) begin
          a     <= data_in;
          state <= FETCH;
        end
        STORE: if (mem_ready) state <= FETCH;
        ALU: begin
          res     <= r_full;
          cy      <= cy_out;
          counter <= counter + 1'b1;
          if (counter == LAST) begin
            counter <= '0;
            c       <= c_new;
            state   <= FETCH;
            if (cls == 2'b10) a <= r_full;
            else begin
              // dest 11 tests c as it was on ALU entry; c is only updated here
              case (dest)
                2'b00: a <= r_full;
                2'b01: b <= r_full;
                2'b10: pc <= r_full;
                default: if (c) pc <= r_full;
              endcase
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_seqpu_serial_core.sv
// Directed bench for seqpu_serial_core: DIGIT=1 and DIGIT=4 instances run the same program memory.
module tb_seqpu_serial_core;
  logic        clk;
  logic        rst;
  logic        mem_ready;
  logic [15:0] address, data_out, data_in;
  logic [15:0] address4, data_out4, data_in4;
  logic        wren_n, flag_c, wren_n4, flag_c4;
  logic [15:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_in  = mem[address[7:0]];
  assign data_in4 = mem[address4[7:0]];

  seqpu_serial_core #(.WIDTH(16), .DIGIT(1), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .address(address), .data_out(data_out), .data_in(data_in),
    .wren_n(wren_n), .mem_ready(mem_ready), .flag_c(flag_c));

  seqpu_serial_core #(.WIDTH(16), .DIGIT(4), .RESET_PC(16'h0000)) dut4 (
    .clk(clk), .rst(rst), .address(address4), .data_out(data_out4), .data_in(data_in4),
    .wren_n(wren_n4), .mem_ready(mem_ready), .flag_c(flag_c4));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    mem_ready = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_mem();
    rst = 1'b1;
    mem_ready = 1'b1;
    step(2);
    checks++; if (address !== 16'h0000) begin errors++; $display("FAIL rst_address: got %h expected %h", address, 16'h0000); end
    checks++; if (wren_n !== 1'b1) begin errors++; $display("FAIL rst_wren_n: got %b expected 1", wren_n); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rst_data_out: got %h expected 0000", data_out); end
    checks++; if (flag_c !== 1'b0) begin errors++; $display("FAIL rst_flag_c: got %b expected 0", flag_c); end
    checks++; if (address4 !== 16'h0000) begin errors++; $display("FAIL rst_address4: got %h expected 0000", address4); end
    rst = 1'b0;
    #2;
    checks++; if (address !== 16'h0000 || wren_n !== 1'b1) begin errors++; $display("FAIL rst_release: got addr %h wren_n %b expected 0000 1", address, wren_n); end
  endtask

  task automatic test_load;
    clear_mem();
    mem[0] = 16'h0005;
    mem[5] = 16'h1234;
    do_reset();
    checks++; if (address !== 16'h0000) begin errors++; $display("FAIL load_fetch_addr: got %h expected 0000", address); end
    step(1);
    checks++; if (address !== 16'h0001) begin errors++; $display("FAIL load_decode_addr: got %h expected 0001", address); end
    step(1);
    checks++; if (address !== 16'h0005 || wren_n !== 1'b1) begin errors++; $display("FAIL load_addr: got %h/%b expected 0005/1", address, wren_n); end
    step(1);
    checks++; if (address !== 16'h0001) begin errors++; $display("FAIL load_next_fetch: got %h expected 0001", address); end
    checks++; if (data_out !== 16'h1234) begin errors++; $display("FAIL load_a: got %h expected 1234", data_out); end
  endtask

  task automatic test_store;
    int low;
    clear_mem();
    mem[0] = 16'h0005;
    mem[5] = 16'h1234;
    mem[1] = 16'h4010;
    do_reset();
    step(5);
    checks++; if (address !== 16'h0010 || data_out !== 16'h1234 || wren_n !== 1'b0) begin
      errors++; $display("FAIL store_entry: got %h/%h/%b expected 0010/1234/0", address, data_out, wren_n); end
    low = 1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (wren_n === 1'b0 && address === 16'h0010) low++;
    end
    mem_ready = 1'b1;
    step(1);
    checks++; if (low !== 4) begin errors++; $display("FAIL store_wait_cycles: got %0d expected 4", low); end
    checks++; if (wren_n !== 1'b1 || address !== 16'h0002) begin errors++; $display("FAIL store_done: got %b/%h expected 1/0002", wren_n, address); end
    mem_ready = 1'b0;
    step(2);
    checks++; if (address !== 16'h0002) begin errors++; $display("FAIL fetch_wait: got %h expected 0002", address); end
    mem_ready = 1'b1;
  endtask

  task automatic test_lit_add;
    clear_mem();
    mem[0] = 16'h0008;
    mem[8] = 16'h0003;
    mem[1] = 16'hF200;
    mem[2] = 16'h8005;
    do_reset();
    for (int i = 1; i <= 39; i++) begin
      step(1);
      if (i == 14) begin
        checks++; if (data_out4 !== 16'h0005) begin errors++; $display("FAIL d4_alu_len: got %h expected 0005", data_out4); end
      end
      if (i == 15) begin
        checks++; if (data_out4 !== 16'h0008 || address4 !== 16'h0003 || flag_c4 !== 1'b0) begin
          errors++; $display("FAIL d4_lit_add: got %h/%h/%b expected 0008/0003/0", data_out4, address4, flag_c4); end
      end
      if (i == 38) begin
        checks++; if (data_out !== 16'h0005) begin errors++; $display("FAIL d1_alu_len: got %h expected 0005", data_out); end
      end
      if (i == 39) begin
        checks++; if (data_out !== 16'h0008 || address !== 16'h0003 || flag_c !== 1'b0) begin
          errors++; $display("FAIL d1_lit_add: got %h/%h/%b expected 0008/0003/0", data_out, address, flag_c); end
      end
    end
  endtask

  task automatic test_carry_sub_shift;
    clear_mem();
    mem[0] = 16'h0021; mem[1] = 16'hF200; mem[2] = 16'h0020; mem[3] = 16'hC000;
    mem[4] = 16'h0022; mem[5] = 16'hF200; mem[6] = 16'h0023; mem[7] = 16'hC800;
    mem[8] = 16'h0024; mem[9] = 16'hF200; mem[10] = 16'hF800;
    mem[8'h20] = 16'hFFFF; mem[8'h21] = 16'h0001; mem[8'h22] = 16'h0003;
    mem[8'h23] = 16'h0002; mem[8'h24] = 16'h8001;
    do_reset();
    step(42);
    checks++; if (address !== 16'h0004 || data_out !== 16'h0000 || flag_c !== 1'b1) begin
      errors++; $display("FAIL add_carry: got %h/%h/%b expected 0004/0000/1", address, data_out, flag_c); end
    step(21);
    checks++; if (flag_c !== 1'b0) begin errors++; $display("FAIL pass_zero_flag: got %b expected 0", flag_c); end
    step(21);
    checks++; if (address !== 16'h0008 || data_out !== 16'hFFFF || flag_c !== 1'b1) begin
      errors++; $display("FAIL sub_borrow: got %h/%h/%b expected 0008/ffff/1", address, data_out, flag_c); end
    step(21);
    checks++; if (address !== 16'h000A || flag_c !== 1'b0) begin errors++; $display("FAIL pre_shift: got %h/%b expected 000a/0", address, flag_c); end
    step(18);
    checks++; if (address !== 16'h000B || data_out !== 16'h0002 || flag_c !== 1'b1) begin
      errors++; $display("FAIL shift: got %h/%h/%b expected 000b/0002/1", address, data_out, flag_c); end
  endtask

  task automatic test_cond_pc;
    clear_mem();
    mem[0] = 16'h0030; mem[8'h30] = 16'h8020; mem[1] = 16'hF800; mem[2] = 16'hF600;
    mem[8'h40] = 16'hF600; mem[8'h41] = 16'h0031; mem[8'h31] = 16'h0000; mem[8'h42] = 16'hF600;
    do_reset();
    step(21);
    checks++; if (address !== 16'h0002 || data_out !== 16'h0040 || flag_c !== 1'b1) begin
      errors++; $display("FAIL cond_setup: got %h/%h/%b expected 0002/0040/1", address, data_out, flag_c); end
    step(18);
    checks++; if (address !== 16'h0040 || flag_c !== 1'b0) begin errors++; $display("FAIL cond_taken: got %h/%b expected 0040/0", address, flag_c); end
    step(18);
    checks++; if (address !== 16'h0041 || flag_c !== 1'b0) begin errors++; $display("FAIL cond_not_taken: got %h/%b expected 0041/0", address, flag_c); end
    step(21);
    checks++; if (address !== 16'h0043 || data_out !== 16'h0000 || flag_c !== 1'b1) begin
      errors++; $display("FAIL cond_zero_flag: got %h/%h/%b expected 0043/0000/1", address, data_out, flag_c); end
  endtask

  task automatic test_pc_wrap;
    clear_mem();
    mem[0] = 16'h0032; mem[8'h32] = 16'hFFFF; mem[1] = 16'hF400;
    mem[8'hFF] = 16'h0033; mem[8'h33] = 16'h5A5A;
    do_reset();
    step(21);
    checks++; if (address !== 16'hFFFF) begin errors++; $display("FAIL jump_ffff: got %h expected ffff", address); end
    step(1);
    checks++; if (address !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %h expected 0000", address); end
    step(1);
    checks++; if (address !== 16'h0033) begin errors++; $display("FAIL wrap_load_addr: got %h expected 0033", address); end
    step(1);
    checks++; if (address !== 16'h0000 || data_out !== 16'h5A5A) begin
      errors++; $display("FAIL wrap_load: got %h/%h expected 0000/5a5a", address, data_out); end
  endtask

  task automatic test_reset_mid_alu;
    clear_mem();
    mem[0] = 16'h0034; mem[8'h34] = 16'h1234; mem[1] = 16'hF200;
    mem[2] = 16'h0035; mem[8'h35] = 16'h8000; mem[3] = 16'hF800;
    mem[4] = 16'h0034; mem[5] = 16'hC000;
    do_reset();
    step(51);
    checks++; if (data_out !== 16'h1234 || flag_c !== 1'b1) begin
      errors++; $display("FAIL mid_alu_pre: got %h/%b expected 1234/1", data_out, flag_c); end
    rst = 1'b1;
    mem[0] = 16'hE000;
    #1;
    checks++; if (address !== 16'h0000 || wren_n !== 1'b1 || data_out !== 16'h0000 || flag_c !== 1'b0) begin
      errors++; $display("FAIL mid_alu_async: got %h/%b/%h/%b expected 0000/1/0000/0", address, wren_n, data_out, flag_c); end
    step(2);
    rst = 1'b0;
    step(2);
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL mid_alu_no_write: got %h expected 0000", data_out); end
    step(16);
    checks++; if (address !== 16'h0001 || data_out !== 16'h0000 || flag_c !== 1'b1) begin
      errors++; $display("FAIL mid_alu_b_cleared: got %h/%h/%b expected 0001/0000/1", address, data_out, flag_c); end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    test_reset();
    test_load();
    test_store();
    test_lit_add();
    test_carry_sub_shift();
    test_cond_pc();
    test_pc_wrap();
    test_reset_mid_alu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
